// File: rtl/receive_engine_pkg.sv
// Shared UART definitions: engine state encoding, bit-time width
// and the frame-length helper used by the receive and transmit engines.
package receive_engine_pkg;

    localparam int BAUD_W = 19;

    // Longest frame: 8 data + parity + stop samples after the start bit
    localparam logic [3:0] FRAME_MAX = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BITS,
        DONE
    } rx_state_t;

    // Samples taken after the start bit: data bits, optional parity, stop
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/receive_engine_bit_time_counter.sv
// Free-running bit-time counter; tick marks the last clock of each
// target-clock interval and the count restarts on tick or clr.
module bit_time_counter #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [BAUD_W-1:0] target,
    output logic              tick
);

    logic [BAUD_W-1:0] count;

    assign tick = (count == target - 1'b1);

    // Count clocks, restarting on every tick or explicit clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/receive_engine.sv
// UART receive engine: synchronizes RX, samples mid-bit, and presents
// a right-justified byte with parity, framing and overrun status.
module receive_engine
    import receive_engine_pkg::*;
#(
    parameter int BAUD_W      = receive_engine_pkg::BAUD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RX,
    input  logic [BAUD_W-1:0] baud,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic              read0,
    output logic [7:0]        rx_data,
    output logic              RXRDY,
    output logic              PERR,
    output logic              FERR,
    output logic              OVF
);

    rx_state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   tick;
    logic                   clr;
    logic [BAUD_W-1:0]      target;

    logic       eight_q, pen_q, ohel_q;
    logic [3:0] bit_cnt_q;
    logic [9:0] sr_q;
    logic [3:0] n_len;

    logic [8:0] aligned;
    logic [7:0] data_w;
    logic       par_bit;
    logic       stop_bit;
    logic       par_bad;

    assign rxs = sync_q[SYNC_STAGES-1];

    // Metastability chain; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end
    end

    assign target = (state_q == START) ? {1'b0, baud[BAUD_W-1:1]} : baud;
    assign clr    = (state_d != state_q) || (state_q == IDLE);

    bit_time_counter #(
        .BAUD_W (BAUD_W)
    ) u_btc (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .target (target),
        .tick   (tick)
    );

    assign n_len = frame_len(eight_q, pen_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: validate start at mid-bit, then count N samples
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START;
            end
            START: begin
                if (tick) state_d = rxs ? IDLE : BITS;
            end
            BITS: begin
                if (tick && (bit_cnt_q + 1'b1 == n_len)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch frame controls at start validation and shift in samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
        end else if (state_q == START && tick && !rxs) begin
            eight_q   <= EIGHT;
            pen_q     <= PEN;
            ohel_q    <= OHEL;
            bit_cnt_q <= '0;
        end else if (state_q == BITS && tick) begin
            sr_q      <= {rxs, sr_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    // Samples enter at the MSB, so shift a short frame down to bit 0
    assign aligned  = 9'(sr_q >> (FRAME_MAX - n_len));
    assign data_w   = eight_q ? aligned[7:0] : {1'b0, aligned[6:0]};
    assign par_bit  = eight_q ? aligned[8] : aligned[7];
    assign stop_bit = sr_q[9];
    assign par_bad  = pen_q & ((^data_w ^ par_bit) != ohel_q);

    // Publish the frame at DONE; read0 alone clears ready and overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data <= '0;
            RXRDY   <= 1'b0;
            PERR    <= 1'b0;
            FERR    <= 1'b0;
            OVF     <= 1'b0;
        end else if (state_q == DONE) begin
            rx_data <= data_w;
            PERR    <= par_bad;
            FERR    <= ~stop_bit;
            RXRDY   <= 1'b1;
            OVF     <= read0 ? 1'b0 : (OVF | RXRDY);
        end else if (read0) begin
            RXRDY   <= 1'b0;
            OVF     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_receive_engine.sv
// Bench for receive_engine: serial frames are driven on RX while the
// expected byte and status are queued, then popped when RXRDY is seen.
module tb_receive_engine;

    localparam int BW   = 19;
    localparam int BAUD = 109;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          RX = 1'b1;
    logic [BW-1:0] baud = BW'(BAUD);
    logic          EIGHT = 1'b1;
    logic          PEN = 1'b1;
    logic          OHEL = 1'b1;
    logic          read0 = 1'b0;
    logic [7:0]    rx_data;
    logic          RXRDY, PERR, FERR, OVF;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   start_cyc = 0;
    logic rdy_d = 1'b0;
    exp_t exp_q[$];

    receive_engine #(
        .BAUD_W      (BW),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .RX      (RX),
        .baud    (baud),
        .EIGHT   (EIGHT),
        .PEN     (PEN),
        .OHEL    (OHEL),
        .read0   (read0),
        .rx_data (rx_data),
        .RXRDY   (RXRDY),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVF     (OVF)
    );

    always #5 clk = ~clk;

    // Cycle counter and RXRDY rising-edge timestamp
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_d <= RXRDY;
        if (RXRDY && !rdy_d) rise_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one frame; rst_at >= 0 pulses reset midway through that bit
    task automatic send_frame(input logic [7:0] d, input logic eight,
                              input logic pen, input logic ohel,
                              input logic bad_par, input logic stop,
                              input logic exp_ovf, input int rst_at);
        logic bits[12];
        int   n;
        logic p;
        exp_t e;
        EIGHT = eight;
        PEN   = pen;
        OHEL  = ohel;
        n = 0;
        bits[n++] = 1'b0;
        for (int i = 0; i < (eight ? 8 : 7); i++) bits[n++] = d[i];
        p = eight ? ^d : ^d[6:0];
        if (pen) bits[n++] = (ohel ? ~p : p) ^ bad_par;
        bits[n++] = stop;
        if (rst_at < 0) begin
            e.data = eight ? d : {1'b0, d[6:0]};
            e.perr = pen & bad_par;
            e.ferr = ~stop;
            e.ovf  = exp_ovf;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            RX = bits[i];
            if (i == rst_at) begin
                repeat (50) @(posedge clk);
                #1 reset = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check("rst_data", rx_data, 0);
                check("rst_rdy", RXRDY, 0);
                check("rst_err", {PERR, FERR, OVF}, 0);
                reset = 1'b0;
                RX = 1'b1;
                return;
            end
            repeat (BAUD) @(posedge clk);
        end
        #1 RX = 1'b1;
    endtask

    // Wait (bounded) for a ready byte and compare it to the queue head
    task automatic expect_byte(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!RXRDY && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_rdy"}, RXRDY, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_data"}, rx_data, e.data);
        check({tag, "_perr"}, PERR, e.perr);
        check({tag, "_ferr"}, FERR, e.ferr);
        check({tag, "_ovf"}, OVF, e.ovf);
    endtask

    task automatic pulse_read;
        @(posedge clk);
        #1 read0 = 1'b1;
        @(posedge clk);
        #1 read0 = 1'b0;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", rx_data, 0);
        check("reset_flags", {RXRDY, PERR, FERR, OVF}, 0);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        send_frame(8'h07, 1, 1, 1, 0, 1, 0, -1);
        expect_byte("f07");
        check("f07_lat_lo", 32'(rise_cyc - start_cyc >= 10 * BAUD), 1);
        check("f07_lat_hi", 32'(rise_cyc - start_cyc <= 11 * BAUD), 1);
        pulse_read();
        check("f07_read_rdy", RXRDY, 0);

        send_frame(8'h07, 1, 1, 1, 1, 1, 0, -1);
        expect_byte("f07p");
        pulse_read();
        check("f07p_read_rdy", RXRDY, 0);
        check("f07p_read_perr", PERR, 1);

        send_frame(8'h55, 0, 0, 1, 0, 0, 0, -1);
        expect_byte("f55");
        check("f55_lat_lo", 32'(rise_cyc - start_cyc >= 8 * BAUD), 1);
        check("f55_lat_hi", 32'(rise_cyc - start_cyc <= 9 * BAUD), 1);
        pulse_read();

        send_frame(8'hA5, 1, 1, 1, 0, 1, 0, -1);
        expect_byte("fA5");
        send_frame(8'h3C, 1, 1, 1, 0, 1, 1, -1);
        expect_byte("f3C");
        pulse_read();
        check("ovf_read_rdy", RXRDY, 0);
        check("ovf_read_ovf", OVF, 0);

        @(posedge clk);
        #1 RX = 1'b0;
        repeat (30) @(posedge clk);
        #1 RX = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("glitch_rdy", RXRDY, 0);
        send_frame(8'h81, 1, 1, 0, 0, 1, 0, -1);
        expect_byte("f81");
        pulse_read();

        send_frame(8'hFF, 1, 1, 1, 0, 1, 0, 5);
        repeat (2 * BAUD) @(posedge clk);
        #1;
        check("post_rst_rdy", RXRDY, 0);
        send_frame(8'h42, 1, 1, 1, 0, 1, 0, -1);
        expect_byte("f42");
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
